llr_fg_pipe: RTL and testbench
==============================

# llr_fg_pipe

Sequenced, pipelined LLR processing element for the SC polar decoder datapath. Accepts a command (mode, pair count), then consumes a stream of LLR pairs (a, b, partial-sum bit u) and emits one signed LLR per pair: f = sign(a)·sign(b)·min(|a|,|b|) or g = b + (1−2u)·a. Sits directly downstream of the LLR memory read port and feeds the LLR write-back buffer of the next decoding stage.

## Interface
- W, 21, LLR width (two's complement)
- LEN_W, 10, pair-count width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command pulse; sampled only in IDLE
- mode  in  1  0 = f, 1 = g; latched with start
- len  in  LEN_W  number of pairs; latched with start
- in_valid / in_ready  in / out  1  input handshake
- in_a, in_b  in  W  signed LLRs
- in_u  in  1  partial-sum bit (g only; ignored in f)
- out_valid / out_ready  out / in  1  output handshake
- out_llr  out  W  signed result
- out_last  out  1  high with the len-th output
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse after last output handshake

## Operation
- FSM: IDLE → RUN on start (len≠0); IDLE → DONE on start with len=0 (no inputs taken, no outputs).
- RUN: accepts pairs until len accepted, then → DRAIN.
- DRAIN: waits for the len-th output handshake, then → DONE.
- DONE: done=1 for one cycle, → IDLE.
- start outside IDLE is ignored; mode/len are not changed by it.
- Counters: in_cnt (accepted), out_cnt (emitted), both LEN_W bits, cleared on start.
- f: zero in either operand → 0. Otherwise magnitude = min(|a|,|b|), sign = sign(a) XOR sign(b). |−2^(W−1)| saturates to 2^(W−1)−1 before compare.
- g: u=0 → b+a; u=1 → b−a; computed at W+1 bits, then reduced to W per Configuration.
- Output order equals input order; no reordering, no drops.

## Timing
- Two register stages: S1 (abs, compare, sum/diff), S2 (select, sign apply, saturate → out_llr).
- Pipe enable pe = !out_valid || out_ready; both stages advance only when pe=1.
- in_ready = (state==RUN) && (in_cnt<len) && pe (combinational from out_ready; accepted path).
- Latency: input handshake at cycle t → out_valid at t+2 with no backpressure. Throughput 1 pair/cycle.
- out_valid/out_llr/out_last held stable while out_valid && !out_ready.
- done asserts the cycle after the final out handshake; busy drops with it (IDLE next cycle).
- Reset values: out_valid=0, out_llr=0, out_last=0, in_ready=0, busy=0, done=0, state=IDLE, counters=0, pipe valids=0.
- rst mid-command: in-flight data discarded, no done pulse, IDLE next cycle.
- Simultaneous out handshake and new input acceptance in the same cycle is legal and required.

## Configuration
- LLR_G_SAT_EN defined: g result clamped to [−(2^(W−1)−1), 2^(W−1)−1].
- Undefined: g result truncated to W bits (two's-complement wrap); f unaffected either way.

## Structure
- Package llr_pkg: W default, mode encoding (MODE_F=0, MODE_G=1), FSM state enum (IDLE, RUN, DRAIN, DONE), saturation limits.
- Sub-module llr_fg_core: combinational f/g arithmetic (abs, min, sign, add/sub, saturate); llr_fg_pipe holds FSM, counters, pipeline registers, handshakes.

## Test plan
- f, len=3: (5,−3),(−7,−2),(0,−9) → −3, 2, 0; out_last on third; done one cycle later.
- f saturation: a=−2^20, b=−2^20 → 2^20−1 (0x0FFFFF).
- g overflow: a=1, b=2^20−1, u=0 → 0x0FFFFF with LLR_G_SAT_EN, 0x100000 (−2^20) without; a=100, b=40, u=1 → −60.
- Backpressure: g, len=4, in_valid always high, out_ready low 5 cycles after first out_valid → in_ready low, held output stable, all 4 results in order, exactly 4 outputs.
- len=0 start → done pulse, no in_ready, no out_valid; start during RUN ignored.
- rst asserted 1 cycle after second input accepted (len=8) → next cycle out_valid=0, busy=0, no done; fresh command then runs normally.

Source files
------------

// File: rtl/llr_fg_pipe_pkg.sv
// llr_pkg: shared definitions for the LLR f/g processing element.
//   LLR_W / LEN_W_D : default LLR width and pair-count width
//   MODE_F / MODE_G : command mode encoding
//   state_t         : sequencer states
//   llr_sat_hi()    : largest symmetric LLR magnitude for a given width
//   llr_sum_w()     : width the g sum is carried at between pipe stages
// Optional feature macro: LLR_G_SAT_EN (g results clamp instead of wrap).
package llr_pkg;

    localparam int LLR_W   = 21;
    localparam int LEN_W_D = 10;

    localparam logic MODE_F = 1'b0;
    localparam logic MODE_G = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Symmetric limit: the most negative code is never produced.
    function automatic longint llr_sat_hi(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    // With clamping the sum needs its carry bit to detect overflow; when
    // wrapping, the carry would be discarded anyway, so it is never kept.
    function automatic int llr_sum_w(input int w);
`ifdef LLR_G_SAT_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/llr_fg_pipe_if.sv
// llr_fg_pipe_if: command, input-stream and output-stream signals of the
// LLR f/g element.
//   start/mode/len   : command (sampled only while idle)
//   in_*             : LLR pair stream (valid/ready)
//   out_*            : result stream (valid/ready), out_last on final result
//   busy/done        : status
// slave modport = processing element, master modport = its driver.
interface llr_fg_pipe_if
    import llr_pkg::*;
#(
    parameter int W     = LLR_W,
    parameter int LEN_W = LEN_W_D
);
    logic                start;
    logic                mode;
    logic [LEN_W-1:0]    len;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_a;
    logic signed [W-1:0] in_b;
    logic                in_u;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_llr;
    logic                out_last;
    logic                busy;
    logic                done;

    modport slave (
        input  start, mode, len, in_valid, in_a, in_b, in_u, out_ready,
        output in_ready, out_valid, out_llr, out_last, busy, done
    );

    modport master (
        output start, mode, len, in_valid, in_a, in_b, in_u, out_ready,
        input  in_ready, out_valid, out_llr, out_last, busy, done
    );
endinterface

// File: rtl/llr_fg_core.sv
// llr_fg_core: combinational f/g arithmetic, split at the pipeline cut.
//   first half  (a, b, u -> s1_*): |a|,|b| with saturation, min, sign XOR,
//                                  b+a / b-a
//   second half (s2_* -> s2_res) : f sign apply, g reduce to W bits
// Optional feature macro: LLR_G_SAT_EN (clamp g to +/-(2^(W-1)-1));
// otherwise g wraps to W bits.
module llr_fg_core
    import llr_pkg::*;
#(
    parameter int W = LLR_W
) (
    input  logic signed [W-1:0]              a,
    input  logic signed [W-1:0]              b,
    input  logic                             u,
    output logic [W-2:0]                     s1_mag,
    output logic                             s1_neg,
    output logic signed [llr_sum_w(W)-1:0]   s1_sum,
    input  logic                             mode,
    input  logic [W-2:0]                     s2_mag,
    input  logic                             s2_neg,
    input  logic signed [llr_sum_w(W)-1:0]   s2_sum,
    output logic signed [W-1:0]              s2_res
);
    localparam int SUM_W = llr_sum_w(W);
`ifdef LLR_G_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(llr_sat_hi(W));
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;
`endif

    logic [W-2:0]        abs_a;
    logic [W-2:0]        abs_b;
    logic signed [W-1:0] mag_s;
    logic signed [W-1:0] f_val;
    logic signed [W-1:0] g_val;

    // Magnitude kept at W-1 bits: the most negative code has no positive
    // twin, so it maps to the all-ones magnitude instead of overflowing.
    always_comb begin
        abs_a = a[W-2:0];
        abs_b = b[W-2:0];
        if (a[W-1]) abs_a = (a[W-2:0] == '0) ? '1 : (~a[W-2:0] + 1'b1);
        if (b[W-1]) abs_b = (b[W-2:0] == '0) ? '1 : (~b[W-2:0] + 1'b1);
        // A zero operand gives a zero minimum, so f of zero is zero
        // regardless of the sign bit.
        s1_mag = (abs_a < abs_b) ? abs_a : abs_b;
        s1_neg = a[W-1] ^ b[W-1];
        s1_sum = u ? (SUM_W'(b) - SUM_W'(a)) : (SUM_W'(b) + SUM_W'(a));
    end

    always_comb begin
        mag_s = {1'b0, s2_mag};
        f_val = s2_neg ? -mag_s : mag_s;
`ifdef LLR_G_SAT_EN
        if (s2_sum > SAT_HI)      g_val = SAT_HI[W-1:0];
        else if (s2_sum < SAT_LO) g_val = SAT_LO[W-1:0];
        else                      g_val = s2_sum[W-1:0];
`else
        g_val = s2_sum;
`endif
        case (mode)
            MODE_F:  s2_res = f_val;
            MODE_G:  s2_res = g_val;
            default: s2_res = '0;
        endcase
    end
endmodule

// File: rtl/llr_fg_pipe.sv
// llr_fg_pipe: sequenced two-stage LLR f/g processing element.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : llr_fg_pipe_if.slave (command, pair stream, result stream,
//               busy/done)
// A command (mode, len) is taken while idle; len pairs are then consumed and
// len results produced in order, the last flagged with out_last, followed by
// a one-cycle done pulse.
// Optional feature macro: LLR_G_SAT_EN (see llr_fg_core).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pairs until len have been taken
// DRAIN | waiting for the len-th result to be handed off
// DONE  | done pulse, back to IDLE
module llr_fg_pipe
    import llr_pkg::*;
#(
    parameter int W     = LLR_W,
    parameter int LEN_W = LEN_W_D
) (
    input  logic            clk,
    input  logic            rst,
    llr_fg_pipe_if.slave    bus
);
    localparam int SUM_W = llr_sum_w(W);
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 mode_q;
    logic [LEN_W-1:0]     len_q, len_m1;
    logic [LEN_W-1:0]     in_cnt, out_cnt;
    logic                 pe, acc, out_hs, in_ready;

    logic                 s1_valid, s1_last, s1_neg;
    logic [W-2:0]         s1_mag;
    logic signed [SUM_W-1:0] s1_sum;
    logic [W-2:0]         c_mag;
    logic                 c_neg;
    logic signed [SUM_W-1:0] c_sum;
    logic signed [W-1:0]  c_res;

    logic                 out_valid_q, out_last_q;
    logic signed [W-1:0]  out_llr_q;

    llr_fg_core #(.W(W)) u_core (
        .a      (bus.in_a),
        .b      (bus.in_b),
        .u      (bus.in_u),
        .s1_mag (c_mag),
        .s1_neg (c_neg),
        .s1_sum (c_sum),
        .mode   (mode_q),
        .s2_mag (s1_mag),
        .s2_neg (s1_neg),
        .s2_sum (s1_sum),
        .s2_res (c_res)
    );

    assign len_m1   = len_q - LEN_ONE;
    assign pe       = !out_valid_q || bus.out_ready;
    assign in_ready = (state_q == RUN) && (in_cnt < len_q) && pe;
    assign acc      = bus.in_valid && in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_llr   = out_llr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
            RUN:     if (acc && (in_cnt == len_m1)) state_d = DRAIN;
            DRAIN:   if (out_hs && (out_cnt == len_m1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_F;
            len_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if ((state_q == IDLE) && bus.start) begin
            mode_q  <= bus.mode;
            len_q   <= bus.len;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (acc)    in_cnt  <= in_cnt + LEN_ONE;
            if (out_hs) out_cnt <= out_cnt + LEN_ONE;
        end
    end

    // Both stages move together; a stalled output freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_mag      <= '0;
            s1_neg      <= 1'b0;
            s1_sum      <= '0;
            out_valid_q <= 1'b0;
            out_llr_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (pe) begin
            s1_valid <= acc;
            if (acc) begin
                s1_mag  <= c_mag;
                s1_neg  <= c_neg;
                s1_sum  <= c_sum;
                s1_last <= (in_cnt == len_m1);
            end
            out_valid_q <= s1_valid;
            out_last_q  <= s1_valid && s1_last;
            if (s1_valid) out_llr_q <= c_res;
        end
    end
endmodule

// File: tb/tb_llr_fg_pipe.sv
`timescale 1ns/1ps
module tb_llr_fg_pipe;
    import llr_pkg::*;

    localparam int W     = LLR_W;
    localparam int LEN_W = LEN_W_D;
    localparam longint LIM = llr_sat_hi(W);
    localparam logic signed [W-1:0] V_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] V_MAX = {1'b0, {(W-1){1'b1}}};

    typedef struct { logic signed [W-1:0] llr; logic last; } exp_t;
    typedef struct { logic signed [W-1:0] a; logic signed [W-1:0] b; logic u; } pair_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llr_fg_pipe_if #(.W(W), .LEN_W(LEN_W)) bus();
    llr_fg_pipe #(.W(W), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    pair_t stim[$];
    logic signed [W-1:0] lit[$];
    int n_out = 0;
    int cyc = 0;
    int first_acc_cyc = 0;
    bit rdy_force = 1'b1;
    bit rdy_val = 1'b0;
    int stall_pct = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: f/g from their arithmetic definition on plain integers.
    function automatic logic signed [W-1:0] ref_llr(input bit m, input longint a,
                                                    input longint b, input bit u);
        longint r, ma, mb;
        logic [63:0] rv;
        if (m == MODE_G) begin
            r = u ? (b - a) : (b + a);
`ifdef LLR_G_SAT_EN
            if (r > LIM)  r = LIM;
            if (r < -LIM) r = -LIM;
`else
            r = r & ((longint'(1) << W) - 1);
            if (r > LIM) r = r - (longint'(1) << W);
`endif
        end else if (a == 0 || b == 0) begin
            r = 0;
        end else begin
            ma = (a < 0) ? -a : a;
            mb = (b < 0) ? -b : b;
            if (ma > LIM) ma = LIM;
            if (mb > LIM) mb = LIM;
            r = (ma < mb) ? ma : mb;
            if ((a < 0) != (b < 0)) r = -r;
        end
        rv = r;
        return rv[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] rand_llr();
        logic [31:0] r;
        logic signed [W-1:0] v;
        r = $urandom;
        case (r[2:0])
            3'd0: v = V_MIN;
            3'd1: v = V_MAX;
            3'd2: v = '0;
            3'd3: v = '1;
            3'd4: begin
                v = {{(W-8){1'b0}}, r[15:8]};
                v = v - W'(128);
            end
            default: v = r[W+2:3];
        endcase
        return v;
    endfunction

    function automatic pair_t rand_pair();
        pair_t p;
        p.a = rand_llr();
        p.b = rand_llr();
        p.u = ($urandom_range(1) == 1);
        return p;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_force) bus.out_ready = rdy_val;
        else           bus.out_ready = ($urandom_range(99) >= stall_pct);
    end

    // Monitor: pops and compares every result handshake; checks hold
    // stability under backpressure and done timing.
    logic signed [W-1:0] held_llr;
    logic held_last;
    bit held_v = 1'b0, last_hs_prev = 1'b0, zstart_prev = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
            last_hs_prev = 1'b0;
            zstart_prev = 1'b0;
        end else begin
            if (held_v)
                chk(bus.out_valid === 1'b1 && bus.out_llr === held_llr && bus.out_last === held_last,
                    "hold_stable", bus.out_llr, held_llr);
            if (bus.done === 1'b1 || last_hs_prev || zstart_prev)
                chk(bus.done === (last_hs_prev || zstart_prev), "done_timing",
                    bus.done, last_hs_prev || zstart_prev);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_output", bus.out_llr, 0);
                end else begin
                    me = sb.pop_front();
                    chk(bus.out_llr === me.llr, "out_llr", bus.out_llr, me.llr);
                    chk(bus.out_last === me.last, "out_last", bus.out_last, me.last);
                end
            end
            held_v       = bus.out_valid && !bus.out_ready;
            held_llr     = bus.out_llr;
            held_last    = bus.out_last;
            last_hs_prev = bus.out_valid && bus.out_ready && bus.out_last;
            zstart_prev  = bus.start && (bus.len == '0) && !bus.busy;
        end
    end

    task automatic run_cmd(input bit m, input int n, input int gap_pct, input int poke_at);
        int acc_n = 0;
        int guard = 0;
        int out0;
        bit got_done = 1'b0;
        pair_t p;
        exp_t e;
        out0 = n_out;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.len   = LEN_W'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk(bus.busy === 1'b1, "busy_after_start", bus.busy, 1);
        p = (stim.size() > 0) ? stim.pop_front() : rand_pair();
        while (acc_n < n && guard < 4000) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            bus.in_a = p.a;
            bus.in_b = p.b;
            bus.in_u = p.u;
            if (poke_at >= 0 && acc_n == poke_at) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
                bus.len   = LEN_W'(1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                e.llr  = (lit.size() > 0) ? lit.pop_front() : ref_llr(m, p.a, p.b, p.u);
                e.last = (acc_n == n - 1);
                sb.push_back(e);
                if (acc_n == 0) first_acc_cyc = cyc;
                acc_n++;
                p = (stim.size() > 0) ? stim.pop_front() : rand_pair();
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk(acc_n == n, "accept_count", acc_n, n);
        guard = 0;
        while (!got_done && guard < 2000) begin
            @(negedge clk);
            if (bus.done === 1'b1) got_done = 1'b1;
            guard++;
        end
        chk(got_done, "done_seen", got_done, 1);
        chk(n_out - out0 == n, "output_count", n_out - out0, n);
        chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        @(negedge clk);
        chk(bus.busy === 1'b0, "idle_after_done", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n, guard, dcnt;
        pair_t p;
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.len = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_u = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(bus.out_valid === 1'b0, "rst_out_valid", bus.out_valid, 0);
        chk(bus.out_llr === '0,     "rst_out_llr",   bus.out_llr, 0);
        chk(bus.out_last === 1'b0,  "rst_out_last",  bus.out_last, 0);
        chk(bus.in_ready === 1'b0,  "rst_in_ready",  bus.in_ready, 0);
        chk(bus.busy === 1'b0,      "rst_busy",      bus.busy, 0);
        chk(bus.done === 1'b0,      "rst_done",      bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // f, len=3, literal expectations
        rdy_force = 1'b1; rdy_val = 1'b1;
        stim.push_back('{a: 5,  b: -3, u: 1'b0});
        stim.push_back('{a: -7, b: -2, u: 1'b0});
        stim.push_back('{a: 0,  b: -9, u: 1'b0});
        lit.push_back(-3); lit.push_back(2); lit.push_back(0);
        run_cmd(MODE_F, 3, 0, -1);

        // f saturation of the most negative code
        stim.push_back('{a: V_MIN, b: V_MIN, u: 1'b0});
        lit.push_back(21'h0FFFFF);
        run_cmd(MODE_F, 1, 0, -1);

        // g overflow and subtraction
        stim.push_back('{a: 1, b: V_MAX, u: 1'b0});
        stim.push_back('{a: 100, b: 40, u: 1'b1});
`ifdef LLR_G_SAT_EN
        lit.push_back(21'h0FFFFF);
`else
        lit.push_back(21'h100000);
`endif
        lit.push_back(-60);
        run_cmd(MODE_G, 2, 0, -1);

        // backpressure: 5 stalled cycles after the first result
        rdy_val = 1'b1;
        fork
            run_cmd(MODE_G, 4, 0, -1);
            begin
                guard = 0;
                @(negedge clk);
                while (bus.out_valid !== 1'b1 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                chk(bus.out_valid === 1'b1, "bp_first_valid", bus.out_valid, 1);
                chk(cyc - first_acc_cyc == 2, "latency", cyc - first_acc_cyc, 2);
                rdy_val = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk(bus.in_ready === 1'b0, "bp_in_ready", bus.in_ready, 0);
                end
                rdy_val = 1'b1;
            end
        join

        // len=0: done only, nothing taken or produced
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.start = 1'b1; bus.mode = MODE_F; bus.len = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            chk(bus.in_ready === 1'b0 && bus.out_valid === 1'b0, "len0_quiet",
                bus.in_ready | bus.out_valid, 0);
            if (bus.done === 1'b1) dcnt++;
        end
        chk(dcnt == 1, "len0_done_count", dcnt, 1);
        bus.in_valid = 1'b0;

        // start during RUN must not disturb the running command
        rdy_force = 1'b0; stall_pct = 30;
        run_cmd(MODE_G, 6, 30, 2);

        // reset one cycle after the second accepted pair
        rdy_force = 1'b1; rdy_val = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = MODE_F; bus.len = LEN_W'(8);
        @(posedge clk); #1;
        bus.start = 1'b0;
        acc_n = 0; guard = 0;
        p = rand_pair();
        while (acc_n < 2 && guard < 50) begin
            bus.in_valid = 1'b1; bus.in_a = p.a; bus.in_b = p.b; bus.in_u = p.u;
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                e.llr = ref_llr(MODE_F, p.a, p.b, p.u);
                e.last = 1'b0;
                sb.push_back(e);
                acc_n++;
                p = rand_pair();
            end
            @(posedge clk); #1;
            guard++;
        end
        chk(acc_n == 2, "rst_mid_accepts", acc_n, 2);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk(bus.out_valid === 1'b0, "rst_mid_out_valid", bus.out_valid, 0);
        chk(bus.busy === 1'b0, "rst_mid_busy", bus.busy, 0);
        dcnt = 0;
        repeat (4) begin
            if (bus.done === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk(dcnt == 0, "rst_mid_no_done", dcnt, 0);
        rdy_force = 1'b0; stall_pct = 20;
        run_cmd(MODE_F, 6, 20, -1);

        // randomized commands
        for (int k = 0; k < 10; k++) begin
            stall_pct = $urandom_range(50);
            run_cmd(($urandom_range(1) == 1), $urandom_range(40, 1), $urandom_range(40), -1);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
